// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing constants, framebuffer defaults and the writer request type
package vga_pkg;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int DATA_W_DEF = 8;
  localparam int FB_W_DEF = 160;
  localparam int FB_H_DEF = 120;
  localparam int PIX_SHIFT_DEF = 2;
  localparam int ADDR_W_DEF = 15;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;
endpackage

// File: rtl/vram_wq.sv
// vram_wq: in-order synchronous write-request FIFO; pushes while full and pops while empty are ignored
module vram_wq #(
  parameter int DEPTH = 4,
  parameter int W = 23
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 din,
  output logic [W-1:0]                 dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  assign dout = mem[rp];
  // entry storage needs no reset; occupancy is tracked by count
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: VGA scan-out / pixel-writer framebuffer arbiter; VRAM_BLANK_ONLY_EN restricts writes to blanking
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF,
  parameter int PIX_SHIFT = PIX_SHIFT_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WQ_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            strobe,
  input  logic                            active,
  input  logic [9:0]                      xpos,
  input  logic [9:0]                      ypos,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic                            mem_we,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [DATA_W-1:0]               pixel,
  output logic                            pixel_valid,
  output logic [$clog2(WQ_DEPTH+1)-1:0]   wq_count
);
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);
  logic display, drain_ok, wslot, push, full, empty, s1_v, s1_a;
  logic [ADDR_W+DATA_W-1:0] head;
  logic [ADDR_W-1:0] disp_addr, head_addr;
  logic [DATA_W-1:0] head_data;
  assign display = strobe & active;
`ifdef VRAM_BLANK_ONLY_EN
  assign drain_ok = !active;
`else
  assign drain_ok = 1'b1;
`endif
  assign wslot = !display & !empty & drain_ok;
  assign wr_ready = !full;
  assign push = wr_valid & wr_ready & ({1'b0, wr_addr} < FB_SIZE);
  assign {head_addr, head_data} = head;
  assign disp_addr = ADDR_W'(ypos >> PIX_SHIFT) * ADDR_W'(FB_W) + ADDR_W'(xpos >> PIX_SHIFT);
  assign mem_we = wslot;
  assign mem_addr = display ? disp_addr : wslot ? head_addr : '0;
  assign mem_wdata = wslot ? head_data : '0;
  vram_wq #(.DEPTH(WQ_DEPTH), .W(ADDR_W + DATA_W)) u_wq (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(wslot),
    .din({wr_addr, wr_data}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(wq_count)
  );
  // two-stage strobe tag pipeline aligned with the synchronous memory read
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1_v <= 1'b0;
      s1_a <= 1'b0;
      pixel_valid <= 1'b0;
      pixel <= '0;
    end else begin
      s1_v <= strobe;
      s1_a <= strobe & active;
      pixel_valid <= s1_v;
      if (s1_v) pixel <= s1_a ? mem_rdata : '0;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with a synchronous-read memory model
module tb_vram_arbiter;
  import vga_pkg::*;
  localparam int AW = 15;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int FBSZ = 19200;
  logic clk = 0, rst = 0, strobe = 0, active = 0, wr_valid = 0;
  logic wr_ready, mem_we, pixel_valid;
  logic [9:0] xpos = 0, ypos = 0;
  logic [AW-1:0] wr_addr = 0, mem_addr;
  logic [DW-1:0] wr_data = 0, mem_wdata, mem_rdata, pixel;
  logic [2:0] wq_count;
  logic [DW-1:0] vmem [0:32767];
  logic [DW-1:0] ref_mem [0:32767];
  wr_req_t exp_wr[$];
  logic [DW-1:0] exp_pix[$];
  wr_req_t mw;
  logic [DW-1:0] mp;
  int vectors = 0, miscompares = 0, mcnt = 0, mnext = 0;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .clk(clk), .rst(rst), .strobe(strobe), .active(active), .xpos(xpos), .ypos(ypos),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel(pixel), .pixel_valid(pixel_valid), .wq_count(wq_count)
  );

  always @(posedge clk) begin
    if (mem_we) vmem[mem_addr] <= mem_wdata;
    mem_rdata <= vmem[mem_addr];
  end

  always @(negedge clk)
    if (rst) begin
      if (pixel_valid) begin
        vectors++;
        if (exp_pix.size() == 0) begin
          miscompares++;
          $display("FAIL pix_unexpected got %h expected none", pixel);
        end else begin
          mp = exp_pix.pop_front();
          if (pixel !== mp) begin
            miscompares++;
            $display("FAIL pix_value got %h expected %h", pixel, mp);
          end
        end
      end
      if (mem_we) begin
        vectors++;
        if (exp_wr.size() == 0) begin
          miscompares++;
          $display("FAIL wr_unexpected got addr %0d data %h expected none", mem_addr, mem_wdata);
        end else begin
          mw = exp_wr.pop_front();
          ref_mem[mw.addr] = mw.data;
          if (mem_addr !== mw.addr || mem_wdata !== mw.data) begin
            miscompares++;
            $display("FAIL wr_order got addr %0d data %h expected addr %0d data %h", mem_addr, mem_wdata, mw.addr, mw.data);
          end
        end
      end
    end

  task automatic drive(input logic s, input logic a, input logic [9:0] x, input logic [9:0] y,
                       input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    logic pop, psh;
    @(posedge clk);
    #1;
    mcnt = mnext;
    strobe = s; active = a; xpos = x; ypos = y;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
`ifdef VRAM_BLANK_ONLY_EN
    pop = !(s && a) && mcnt > 0 && !a;
`else
    pop = !(s && a) && mcnt > 0;
`endif
    psh = wv && mcnt < DEPTH && int'(wa) < FBSZ;
    if (psh) exp_wr.push_back('{addr: wa, data: wd});
    if (s) exp_pix.push_back(a ? ref_mem[(int'(y) >> 2) * 160 + (int'(x) >> 2)] : 8'h00);
    mnext = mcnt + int'(psh) - int'(pop);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if ({pixel, pixel_valid, wq_count, wr_ready, mem_we, mem_addr} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 15'd0}) begin
      miscompares++;
      $display("FAIL reset_vals got pix=%h pv=%b cnt=%0d rdy=%b we=%b addr=%0d expected 0/0/0/1/0/0", pixel, pixel_valid, wq_count, wr_ready, mem_we, mem_addr);
    end
    @(negedge clk) rst = 1;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) drive(1, 1, 10'(4 * i), 0, 1, 15'(20 + i), 8'(8'hC0 + i));
    drive(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (wq_count !== 3'd3) begin
      miscompares++;
      $display("FAIL rmid_count got %0d expected 3", wq_count);
    end
    #2;
    strobe = 0; active = 0; wr_valid = 0; rst = 0;
    exp_wr.delete(); exp_pix.delete(); mcnt = 0; mnext = 0;
    #1;
    vectors++;
    if ({pixel, pixel_valid, wq_count, wr_ready, mem_we, mem_addr} !== {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 15'd0}) begin
      miscompares++;
      $display("FAIL rmid_vals got pix=%h pv=%b cnt=%0d rdy=%b we=%b addr=%0d expected 0/0/0/1/0/0", pixel, pixel_valid, wq_count, wr_ready, mem_we, mem_addr);
    end
    @(negedge clk) rst = 1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      vectors++;
      if (mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL rmid_nowrite got %b expected 0", mem_we);
      end
    end
  endtask

  task automatic test_display;
    drive(1, 1, 8, 4, 0, 0, 0);
    vectors++;
    if (mem_addr !== 15'd162 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_addr got addr=%0d we=%b expected 162/0", mem_addr, mem_we);
    end
    idle(1);
    vectors++;
    if (pixel_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL disp_early got pv=%b expected 0", pixel_valid);
    end
    idle(1);
    vectors++;
    if (pixel_valid !== 1'b1 || pixel !== 8'h5A) begin
      miscompares++;
      $display("FAIL disp_pixel got pv=%b pix=%h expected 1/5a", pixel_valid, pixel);
    end
    drive(1, 1, 639, 479, 0, 0, 0);
    vectors++;
    if (mem_addr !== 15'd19199) begin
      miscompares++;
      $display("FAIL disp_corner got %0d expected 19199", mem_addr);
    end
    idle(2);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) drive(1, 1, 10'(4 * i + 1), 10'(8 + i), 0, 0, 0);
    idle(2);
  endtask

  task automatic test_blank;
    drive(1, 1, 0, 0, 1, 10, 8'h33);
    drive(1, 0, 0, 0, 0, 0, 0);
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 15'd10 || mem_wdata !== 8'h33) begin
      miscompares++;
      $display("FAIL blank_write got we=%b addr=%0d data=%h expected 1/10/33", mem_we, mem_addr, mem_wdata);
    end
    idle(2);
    vectors++;
    if (pixel_valid !== 1'b1 || pixel !== 8'h00) begin
      miscompares++;
      $display("FAIL blank_pixel got pv=%b pix=%h expected 1/00", pixel_valid, pixel);
    end
  endtask

  task automatic test_fifo_full;
    for (int i = 0; i < 4; i++) drive(1, 1, 10'(4 * i), 0, 1, 15'(100 + i), 8'(8'h10 + i));
    drive(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (wq_count !== 3'd4 || wr_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_state got cnt=%0d rdy=%b expected 4/0", wq_count, wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0, i == 0, 200, 8'h77);
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 15'(100 + i) || wr_ready !== (i != 0)) begin
        miscompares++;
        $display("FAIL full_drain%0d got we=%b addr=%0d rdy=%b expected 1/%0d/%b", i, mem_we, mem_addr, wr_ready, 100 + i, i != 0);
      end
    end
    drive(1, 1, 0, 0, 1, 300, 8'h44);
    drive(0, 0, 0, 0, 1, 301, 8'h45);
    drive(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (wq_count !== 3'd1) begin
      miscompares++;
      $display("FAIL pushpop_count got %0d expected 1", wq_count);
    end
    idle(3);
  endtask

  task automatic test_out_of_range;
    drive(1, 1, 0, 0, 1, 15'(FBSZ), 8'hEE);
    drive(1, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (wq_count !== 3'd0 || wr_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL oor_count got cnt=%0d rdy=%b expected 0/1", wq_count, wr_ready);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      vectors++;
      if (mem_we !== 1'b0) begin
        miscompares++;
        $display("FAIL oor_nowrite got %b expected 0", mem_we);
      end
    end
  endtask

  task automatic test_gaps;
    drive(1, 1, 0, 4, 1, 400, 8'hA1);
    drive(1, 1, 4, 4, 1, 401, 8'hA2);
    for (int i = 0; i < 8; i++) begin
      drive(i % 4 == 3, 1, 10'(8 * i), 12, 0, 0, 0);
`ifdef VRAM_BLANK_ONLY_EN
      vectors++;
      if (mem_we !== 1'b0 || wq_count !== 3'd2) begin
        miscompares++;
        $display("FAIL gap_hold%0d got we=%b cnt=%0d expected 0/2", i, mem_we, wq_count);
      end
`else
      vectors++;
      if (mem_we !== (i < 2)) begin
        miscompares++;
        $display("FAIL gap_slot%0d got we=%b expected %b", i, mem_we, i < 2);
      end
`endif
    end
    idle(3);
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      vmem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    vmem[162] = 8'h5A;
    ref_mem[162] = 8'h5A;
    test_reset;
    test_reset_mid;
    test_display;
    test_back_to_back;
    test_blank;
    test_fifo_full;
    test_out_of_range;
    test_gaps;
    idle(4);
    vectors++;
    if (exp_pix.size() != 0 || exp_wr.size() != 0) begin
      miscompares++;
      $display("FAIL drain_end got pix=%0d wr=%0d outstanding expected 0/0", exp_pix.size(), exp_wr.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port framebuffer arbiter between VGA scan-out and the game-logic pixel writer. It sits beside the 640x480 VGA timing generator and consumes that generator's `strobe`, `active`, `xpos` and `ypos`. Every active pixel strobe gets a guaranteed display read. Writer requests are buffered in a small FIFO and drained into otherwise idle memory cycles.

## Interface
Parameters:
- `DATA_W`, 8: pixel/colour width.
- `FB_W`, 160: framebuffer width in stored pixels.
- `FB_H`, 120: framebuffer height in stored pixels.
- `PIX_SHIFT`, 2: screen-to-framebuffer downscale; shift applied to `xpos`/`ypos`.
- `ADDR_W`, 15: memory address width; must satisfy 2^`ADDR_W` >= `FB_W`*`FB_H`.
- `WQ_DEPTH`, 4: write FIFO depth; power of two, >= 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `strobe` in 1: pixel-clock enable, the same signal that advances the timing generator.
- `active` in 1: timing-generator drawing phase.
- `xpos` in 10: current pixel X, 0-639.
- `ypos` in 10: current pixel Y, 0-479.
- `wr_valid` in 1: writer request.
- `wr_ready` out 1: FIFO can accept a request.
- `wr_addr` in `ADDR_W`: writer framebuffer address.
- `wr_data` in `DATA_W`: writer pixel value.
- `mem_addr` out `ADDR_W`: memory address, combinational.
- `mem_we` out 1: memory write enable, combinational.
- `mem_wdata` out `DATA_W`: memory write data.
- `mem_rdata` in `DATA_W`: synchronous-read data, valid the cycle after a read is presented.
- `pixel` out `DATA_W`: colour to DAC.
- `pixel_valid` out 1: one-clk pulse when `pixel` updates.
- `wq_count` out clog2(`WQ_DEPTH`+1): FIFO occupancy.

## Operation
- **Display slot.** A cycle with `strobe`=1 and `active`=1 is a display slot.
  - The block drives `mem_we`=0 and `mem_addr` = (`ypos`>>`PIX_SHIFT`)*`FB_W` + (`xpos`>>`PIX_SHIFT`), computed at `ADDR_W` width.
  - A display slot always wins; the writer never gets the memory in that cycle.
- **Write slot.** Any cycle that is not a display slot, with the FIFO non-empty and the drain permitted (see Configuration), is a write slot.
  - The block pops the FIFO head and drives `mem_we`=1, `mem_addr`/`mem_wdata` = head.
- **Idle.** `mem_we`=0 and `mem_addr`=0.
- **Write handshake.**
  - A transfer occurs on a clk edge where `wr_valid`=1 and `wr_ready`=1.
  - `wr_ready` = !full. It is independent of `wr_valid`.
  - A request with `wr_addr` >= `FB_W`*`FB_H` completes the handshake but is discarded and not enqueued.
- **FIFO.** `WQ_DEPTH` entries, in-order.
  - Push and pop in the same cycle leave `wq_count` unchanged.
  - No push occurs when full. A pop while full frees a slot, but `wr_ready` rises only the following cycle.
- **Scan-out pipeline.** A two-stage flag pipeline tags each strobe as `active` or blank.
  - Stage 2 loads `pixel` with `mem_rdata` for an active strobe, or with 0 for a blank strobe.
  - `pixel_valid` pulses on every strobe-driven update.
- **No hazard check.** A display read of an address with a pending FIFO write returns the old value.

## Timing
- **Reset values** (asynchronous): `pixel`=0, `pixel_valid`=0, `wq_count`=0, `wr_ready`=1, pipeline flags cleared.
  - Queued writes are lost on reset.
  - With no strobe present during reset, `mem_we`=0 and `mem_addr`=0.
- **Display latency.** Display slot in cycle T: memory samples at edge T+1; `pixel` and `pixel_valid` update at edge T+2.
  - The pipeline accepts a new strobe every clk.
- **Write latency.** Handshake at edge E: the earliest memory write is in cycle E+1, when the FIFO was previously empty and that cycle is a write slot.
- **Writer starvation.** With `strobe` tied high (clk = pixel clock), writes drain only while `active`=0.

## Configuration
- `VRAM_BLANK_ONLY_EN` defined:
  - Write slots are permitted only when `active`=0, for tear-free updates.
  - The FIFO holds its contents through the whole active region.
- Not defined: write slots are permitted in any non-display cycle, including clks between strobes during the active region.

## Structure
- **Shared package `vga_pkg`:**
  - timing constants: H active 640, V active 480.
  - defaults for `FB_W`, `FB_H`, `PIX_SHIFT`, `DATA_W`.
  - typedef for the write request (`{addr, data}`).
- **Sub-module `vram_wq`:** synchronous FIFO (push/pop/full/empty/count) instantiated once. The arbitration mux and scan-out pipeline live in `vram_arbiter`.

## Test plan
- **Reset mid-operation.** Reset with 3 queued writes, then release → `wq_count`=0, `wr_ready`=1, `pixel`=0, and no `mem_we` pulse until a new push.
- **Display read.** `strobe`=1, `active`=1, `xpos`=8, `ypos`=4 → `mem_addr`=162 that cycle, `mem_we`=0; memory holds 0x5A → `pixel`=0x5A with `pixel_valid`=1 two edges later.
- **Blank strobe.** `strobe`=1, `active`=0 → `pixel`=0 two edges later; a queued write (addr 10, data 0x33) drives `mem_we`=1 in that cycle.
- **FIFO full.** Push 4 writes with `strobe` and `active` held high (macro defined) → `wq_count`=4, `wr_ready`=0. Deassert `active` → one pop per clk in order, and `wr_ready` rises the cycle after the first pop.
- **Out-of-range write.** `wr_addr`=19200 handshakes → `wq_count` unchanged, no memory write.
- **Macro undefined.** `strobe` every 4th clk with `active`=1 and 2 queued writes → both writes issue in the non-strobe clks, and display reads are unaffected.
